// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: imem request/response, redirect and core-side instruction handshake.
interface inst_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_valid, imem_rdata, redirect, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_valid, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: single-outstanding instruction fetcher feeding a PC-tagged FIFO to the core.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic clock,
    input logic reset,
    inst_fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n, issue_addr, req_addr;
    logic [AW:0] count, occ;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0] fifo_inst [DEPTH];
    logic [31:0] fifo_pc [DEPTH];
    logic        valid, pop, push, space, issue, req;
    always_comb begin
        valid      = count != '0;
        pop        = valid & bus.inst_ready;
        push       = (state == WAIT) & bus.imem_valid & ~bus.redirect;
        occ        = count - (AW+1)'(pop) + (AW+1)'(push);
        space      = occ < (AW+1)'(DEPTH);
        state_n    = state;
        fetch_pc_n = fetch_pc;
        issue      = 1'b0;
        issue_addr = fetch_pc;
        if (bus.redirect) begin
            // a response landing with the redirect closes the old fetch, so no DROP is needed
            fetch_pc_n = bus.redirect_pc;
            state_n    = (state == IDLE || bus.imem_valid) ? IDLE : DROP;
        end else if (state == IDLE) begin
            issue   = space;
            state_n = space ? WAIT : IDLE;
        end else if (state == WAIT) begin
            if (bus.imem_valid) begin
                fetch_pc_n = fetch_pc + 32'd1;
                issue_addr = fetch_pc + 32'd1;
                issue      = space;
                state_n    = space ? WAIT : IDLE;
            end
        end else if (bus.imem_valid) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            req      <= 1'b0;
            req_addr <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req      <= issue;
            if (issue) req_addr <= issue_addr;
            if (bus.redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= occ;
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_inst[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]   <= fetch_pc;
        end
    end
    assign bus.imem_req   = req;
    assign bus.imem_addr  = req_addr;
    assign bus.inst_valid = valid;
    assign bus.inst_out   = valid ? fifo_inst[rd_ptr] : '0;
    assign bus.inst_pc    = valid ? fifo_pc[rd_ptr] : '0;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed checks of fetch, buffering, redirect and reset behaviour.
module tb_inst_fetch_queue;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int dly = 0;
    logic [31:0] paddr = '0;
    inst_fetch_queue_if bus();
    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEADBEEF;
    endfunction
    // memory model: one request at a time, responds mem_lat cycles after the request cycle
    always @(negedge clock) begin
        bus.imem_valid = 1'b0;
        if (dly > 0) begin
            dly--;
            if (dly == 0) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = word(paddr);
            end
        end
        if (bus.imem_req === 1'b1) begin
            paddr = bus.imem_addr;
            dly = mem_lat;
        end
    end
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        dly = 0;
        bus.imem_valid = 1'b0;
        bus.redirect = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask
    task automatic test_reset();
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b1;
        reset = 1'b1;
        tick();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.imem_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.inst_valid); end
        checks++; if (bus.inst_out !== 32'h0 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", bus.inst_out, bus.inst_pc); end
        reset = 1'b0;
    endtask
    task automatic test_stream();
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req got %b@%h exp 1@0", bus.imem_req, bus.imem_addr); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL stream_gap%0d got valid=%b req=%b exp 0 0", k, bus.inst_valid, bus.imem_req); end
            tick();
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(k) || bus.inst_out !== word(32'(k))) begin errors++; $display("FAIL stream_out%0d got %b %h %h exp 1 %h %h", k, bus.inst_valid, bus.inst_pc, bus.inst_out, 32'(k), word(32'(k))); end
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(k + 1)) begin errors++; $display("FAIL stream_req%0d got %b@%h exp 1@%h", k, bus.imem_req, bus.imem_addr, 32'(k + 1)); end
        end
    endtask
    task automatic test_fill();
        int n;
        logic [31:0] last;
        do_reset();
        mem_lat = 1;
        bus.inst_ready = 1'b0;
        n = 0;
        last = '0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.imem_req === 1'b1) begin n++; last = bus.imem_addr; end
        end
        checks++; if (n != 4 || last !== 32'h3) begin errors++; $display("FAIL fill_reqs got %0d last %h exp 4 last 3", n, last); end
        checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL fill_hold got req=%b valid=%b pc=%h exp 0 1 0", bus.imem_req, bus.inst_valid, bus.inst_pc); end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.inst_pc !== 32'h1) begin errors++; $display("FAIL fill_pop got req=%b addr=%h pc=%h exp 1 4 1", bus.imem_req, bus.imem_addr, bus.inst_pc); end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.imem_req === 1'b1) n++;
        end
        checks++; if (n != 0 || bus.inst_pc !== 32'h1) begin errors++; $display("FAIL fill_refull got %0d reqs pc=%h exp 0 reqs pc=1", n, bus.inst_pc); end
    endtask
    task automatic test_redirect_wait();
        logic found;
        logic got_req;
        logic [31:0] first_addr;
        do_reset();
        mem_lat = 3;
        bus.inst_ready = 1'b1;
        tick();
        tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_flush got req=%b valid=%b exp 0 0", bus.imem_req, bus.inst_valid); end
        found = 1'b0;
        got_req = 1'b0;
        first_addr = '0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick();
            if (bus.imem_req === 1'b1 && !got_req) begin got_req = 1'b1; first_addr = bus.imem_addr; end
            if (bus.inst_valid === 1'b1) found = 1'b1;
        end
        checks++; if (!got_req || first_addr !== 32'h40) begin errors++; $display("FAIL rdw_req got %b@%h exp 1@40", got_req, first_addr); end
        checks++; if (!found || bus.inst_pc !== 32'h40 || bus.inst_out !== word(32'h40)) begin errors++; $display("FAIL rdw_out got %b %h %h exp 1 40 %h", found, bus.inst_pc, bus.inst_out, word(32'h40)); end
        mem_lat = 1;
    endtask
    task automatic test_redirect_valid();
        do_reset();
        mem_lat = 1;
        bus.inst_ready = 1'b0;
        repeat (6) tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL rdv_pre got %b %h exp 1 0", bus.inst_valid, bus.inst_pc); end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h10;
        bus.inst_ready = 1'b1;
        tick();
        bus.redirect = 1'b0;
        bus.inst_ready = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL rdv_flush got valid=%b req=%b exp 0 0", bus.inst_valid, bus.imem_req); end
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin errors++; $display("FAIL rdv_req got %b@%h exp 1@10", bus.imem_req, bus.imem_addr); end
        tick();
        tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h10 || bus.inst_out !== word(32'h10)) begin errors++; $display("FAIL rdv_out got %b %h %h exp 1 10 %h", bus.inst_valid, bus.inst_pc, bus.inst_out, word(32'h10)); end
    endtask
    task automatic test_reset_wait();
        do_reset();
        mem_lat = 1;
        bus.inst_ready = 1'b0;
        repeat (7) tick();
        mem_lat = 3;
        tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin errors++; $display("FAIL rst_pre got %b %h exp 1 0", bus.inst_valid, bus.inst_pc); end
        reset = 1'b1;
        #1;
        checks++; if (bus.inst_valid !== 1'b0 || bus.inst_out !== 32'h0 || bus.inst_pc !== 32'h0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_async got %b %h %h %b exp 0 0 0 0", bus.inst_valid, bus.inst_out, bus.inst_pc, bus.imem_req); end
        tick();
        tick();
        reset = 1'b0;
        mem_lat = 1;
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_restart got req=%b addr=%h valid=%b exp 1 0 0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
        tick();
        tick();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_out !== word(32'h0)) begin errors++; $display("FAIL rst_out got %b %h %h exp 1 0 %h", bus.inst_valid, bus.inst_pc, bus.inst_out, word(32'h0)); end
    endtask
    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFFFFFF;
        exp_pc[1] = 32'h0;
        exp_pc[2] = 32'h1;
        do_reset();
        mem_lat = 1;
        bus.inst_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFFFFFF;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL wrap_noreq got %b exp 0", bus.imem_req); end
        tick();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_req got %b@%h exp 1@ffffffff", bus.imem_req, bus.imem_addr); end
        for (int k = 0; k < 3; k++) begin
            tick();
            tick();
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc[k] || bus.inst_out !== word(exp_pc[k])) begin errors++; $display("FAIL wrap_out%0d got %b %h %h exp 1 %h %h", k, bus.inst_valid, bus.inst_pc, bus.inst_out, exp_pc[k], word(exp_pc[k])); end
            checks++; if (bus.imem_addr !== exp_pc[k] + 32'd1) begin errors++; $display("FAIL wrap_addr%0d got %h exp %h", k, bus.imem_addr, exp_pc[k] + 32'd1); end
        end
    endtask
    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_redirect_wait();
        test_redirect_valid();
        test_reset_wait();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle core's decode/execute path.
- Issues word-addressed fetch requests to instruction memory over a request/response handshake, one request outstanding at a time.
- Buffers returned instructions, each tagged with its PC, in a small FIFO and presents them to the core with a valid/ready handshake.
- Accepts redirects (jump, jr, taken branch) that flush the buffer and discard any in-flight response.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
RESET_PC, 32'h0, fetch PC loaded on reset.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  one-cycle pulse that starts a fetch at imem_addr.
imem_addr  output  32  word address of the fetch; valid only while imem_req=1.
imem_valid  input  1  response strobe; arrives 1 or more cycles after imem_req.
imem_rdata  input  32  instruction word; valid only while imem_valid=1.
redirect  input  1  flush and restart fetch at redirect_pc.
redirect_pc  input  32  new fetch address (word address).
inst_valid  output  1  FIFO head holds an instruction.
inst_ready  input  1  core consumes the head this cycle.
inst_out  output  32  instruction at the FIFO head.
inst_pc  output  32  word PC of inst_out.

Behaviour:
- Reset values (asynchronous): fetch_pc=RESET_PC, FIFO empty (count=0, read/write pointers 0), state=IDLE, imem_req=0, imem_addr=0, inst_valid=0, inst_out=0, inst_pc=0.
- PC arithmetic: word addressed. fetch_pc increments by 1 per accepted response, mod 2^32; wrap from 32'hFFFFFFFF to 0 is silent.
- FIFO:
  - inst_valid = (count != 0); inst_out and inst_pc come from the head entry.
  - Pop occurs when inst_valid & inst_ready. Push occurs on an accepted response.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Issue condition: space = (count - pop + push) < DEPTH, evaluated on the next-cycle occupancy.
- State machine, registered imem_req:
  - IDLE: if space and no redirect, pulse imem_req with imem_addr=fetch_pc and go to WAIT; otherwise hold IDLE.
  - WAIT: on imem_valid, push {fetch_pc, imem_rdata} and set fetch_pc=fetch_pc+1. If space, issue the next request in the same cycle (address fetch_pc+1) and stay in WAIT; else go to IDLE.
  - DROP: on imem_valid, discard the data (no push, no PC change) and go to IDLE.
- Throughput: with 1-cycle memory latency and the core always ready, the block sustains one instruction every 2 cycles (req, then response plus next req).
- Redirect (highest priority):
  - Always: count:=0, pointers:=0, fetch_pc:=redirect_pc, no imem_req pulse that cycle.
  - In IDLE: stay IDLE; a request to redirect_pc issues the next cycle.
  - In WAIT without imem_valid: go to DROP.
  - In WAIT with imem_valid in the same cycle: discard the response and go to IDLE.
  - In DROP: stay DROP, fetch_pc updated (a second redirect simply overwrites).
  - A pop coinciding with redirect still counts as consumed by the core; the flush wins for FIFO state.
- Latency: a request pulses at cycle t, the response arrives at t+L, and inst_valid/inst_out reflect it at t+L+1.
- imem_valid while IDLE is a protocol error: ignored, no push.
- Reset asserted mid-operation clears everything immediately. A response arriving after reset deasserts is ignored, because the block is in IDLE.

Test Plan:
- Reset then release, 1-cycle memory, inst_ready=1 -> first imem_req one cycle after release with addr 0. Outputs appear with inst_pc=0,1,2,... matching memory words, one every 2 cycles.
- inst_ready=0, 1-cycle memory, DEPTH=4 -> exactly 4 requests (addrs 0..3), then imem_req stays 0 and inst_valid=1 with inst_pc=0. Raising inst_ready for one cycle -> exactly one new request, addr 4.
- Redirect to 32'h40 while in WAIT, memory latency 3 -> the pending response is dropped and never appears. Next request goes to addr 0x40, and the first inst_pc out is 0x40.
- Redirect to 32'h10 in the same cycle as imem_valid and inst_ready with 2 entries buffered -> FIFO empty next cycle, no push of that response, next imem_addr = 0x10.
- Reset asserted while in WAIT with 3 entries buffered -> outputs zero asynchronously. After release, the late imem_valid is ignored and fetch restarts at RESET_PC.
- redirect_pc=32'hFFFFFFFF, inst_ready=1 -> inst_pc sequence FFFFFFFF, 00000000, 00000001.
